instbuf: RTL and testbench

Circular instruction buffer between fetch and decode. It accepts up to INWIDTH fetched 32-bit instructions per cycle and presents up to OUTWIDTH of the oldest entries to the decoder in program order. It decouples fetch-packet timing from decode stalls and discards all contents on a pipeline squash.

---
 rtl/instbuf_pkg.sv | 13 +
 rtl/instbuf_ram.sv | 36 +++
 rtl/instbuf.sv | 144 ++++++++++++++
 tb/tb_instbuf.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instbuf_pkg.sv
// Shared types for the fetch/decode instruction buffer.
// Fetch and decode both import these so an entry has one layout everywhere.
package instbuf_pkg;

  localparam int unsigned InstWidth = 32;
  localparam int unsigned PcWidth   = 64;

  typedef struct packed {
    logic [InstWidth-1:0] inst;
    logic [PcWidth-1:0]   pc;
  } instbuf_entry_t;

endpackage

// File: rtl/instbuf_ram.sv
// Entry storage for instbuf: INWIDTH write lanes at wr_base+k and OUTWIDTH
// read lanes at rd_base+k, addresses wrapping modulo DEPTH. Not reset.
module instbuf_ram
  import instbuf_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned INWIDTH  = 4,
  parameter int unsigned OUTWIDTH = 4
) (
  input  logic                                clk,
  input  logic           [INWIDTH-1:0]        wr_en,
  input  logic           [$clog2(DEPTH)-1:0]  wr_base,
  input  instbuf_entry_t [INWIDTH-1:0]        wr_data,
  input  logic           [$clog2(DEPTH)-1:0]  rd_base,
  output instbuf_entry_t [OUTWIDTH-1:0]       rd_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  instbuf_entry_t mem [DEPTH];

  // Write each enabled lane into consecutive wrapped slots.
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(INWIDTH); k++) begin
      if (wr_en[k]) mem[wr_base + AW'(k)] <= wr_data[k];
    end
  end

  // Read the OUTWIDTH slots starting at the head.
  always_comb begin
    for (int k = 0; k < int'(OUTWIDTH); k++) begin
      rd_data[k] = mem[rd_base + AW'(k)];
    end
  end

endmodule

// File: rtl/instbuf.sv
// Circular instruction buffer between fetch and decode.
// Optional macro INSTBUF_BYPASS_EN: when the buffer is empty, enqueue lanes
// are forwarded straight to the decode lanes in the same cycle.
module instbuf
  import instbuf_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned INWIDTH  = 4,
  parameter int unsigned OUTWIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_squash,
  input  logic [INWIDTH-1:0]            i_enq_vld,
  input  logic [32*INWIDTH-1:0]         i_enq_inst,
  input  logic [64*INWIDTH-1:0]         i_enq_pc,
  output logic                          o_can_enq,
  output logic [OUTWIDTH-1:0]           o_deq_vld,
  output logic [32*OUTWIDTH-1:0]        o_deq_inst,
  output logic [64*OUTWIDTH-1:0]        o_deq_pc,
  input  logic                          i_deq_rdy,
  output logic [$clog2(DEPTH):0]        o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic [PW-1:0] n_enq, n_wr, n_deq, n_byp, n_skip, n_avail;
  logic          enq_run, enq_fire, byp_take;
  logic [INWIDTH-1:0] wr_en;
  instbuf_entry_t [INWIDTH-1:0]  enq_entry, wr_data;
  instbuf_entry_t [OUTWIDTH-1:0] rd_data;

  assign o_can_enq = (count_q <= PW'(DEPTH - INWIDTH));
  assign o_count   = count_q;
  assign n_avail   = (count_q < PW'(OUTWIDTH)) ? count_q : PW'(OUTWIDTH);

  // Unpack lanes and count leading valid lanes from lane 0.
  always_comb begin
    n_enq   = '0;
    enq_run = 1'b1;
    for (int k = 0; k < int'(INWIDTH); k++) begin
      enq_entry[k].inst = i_enq_inst[32*k +: 32];
      enq_entry[k].pc   = i_enq_pc[64*k +: 64];
      if (enq_run && i_enq_vld[k]) n_enq = n_enq + PW'(1);
      else                         enq_run = 1'b0;
    end
  end

  // Bypass lane count; zero unless the buffer is empty and not squashing.
  always_comb begin
    n_byp = '0;
`ifdef INSTBUF_BYPASS_EN
    if (count_q == '0 && !i_squash) begin
      n_byp = (n_enq < PW'(OUTWIDTH)) ? n_enq : PW'(OUTWIDTH);
    end
`endif
  end

  // Accept/write decision; bypass-consumed lanes are skipped when writing.
  always_comb begin
    enq_fire = (n_enq != '0) && o_can_enq && !i_squash;
    byp_take = i_deq_rdy && (n_byp != '0);
    n_skip   = byp_take ? n_byp : '0;
    n_wr     = enq_fire ? (n_enq - n_skip) : '0;
    n_deq    = (i_deq_rdy && !i_squash) ? n_avail : '0;
    for (int j = 0; j < int'(INWIDTH); j++) begin
      wr_en[j]   = (PW'(j) < n_wr);
      wr_data[j] = '0;
      for (int s = 0; s < int'(INWIDTH); s++) begin
        if (PW'(s) == PW'(j) + n_skip) wr_data[j] = enq_entry[s];
      end
    end
  end

  // Decode lanes: from the array when occupied, else from bypass lanes.
  always_comb begin
    o_deq_vld  = '0;
    o_deq_inst = '0;
    o_deq_pc   = '0;
    for (int k = 0; k < int'(OUTWIDTH); k++) begin
      if (count_q != '0) begin
        o_deq_vld[k]          = !i_squash && (PW'(k) < count_q);
        o_deq_inst[32*k +: 32] = rd_data[k].inst;
        o_deq_pc[64*k +: 64]   = rd_data[k].pc;
      end else begin
        o_deq_vld[k] = (PW'(k) < n_byp);
        for (int s = 0; s < int'(INWIDTH); s++) begin
          if (s == k) begin
            o_deq_inst[32*k +: 32] = enq_entry[s].inst;
            o_deq_pc[64*k +: 64]   = enq_entry[s].pc;
          end
        end
      end
    end
  end

  // Pointer and occupancy next state; squash clears everything.
  always_comb begin
    head_d  = head_q + n_deq;
    tail_d  = tail_q + n_wr;
    count_d = count_q + n_wr - n_deq;
    if (i_squash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  instbuf_ram #(
    .DEPTH    (DEPTH),
    .INWIDTH  (INWIDTH),
    .OUTWIDTH (OUTWIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_base (tail_q[AW-1:0]),
    .wr_data (wr_data),
    .rd_base (head_q[AW-1:0]),
    .rd_data (rd_data)
  );

  // Wrap bit sanity: empty means equal pointers, full means same slot, other lap.
  ptr_empty_a: assert property (@(posedge clk) disable iff (rst)
    (count_q == '0) |-> (head_q == tail_q));
  ptr_full_a: assert property (@(posedge clk) disable iff (rst)
    (count_q == PW'(DEPTH)) |-> (head_q[AW-1:0] == tail_q[AW-1:0] &&
                                 head_q[AW] != tail_q[AW]));

endmodule

// File: tb/tb_instbuf.sv
// Directed self-checking bench for instbuf (DEPTH 16, 4 in / 4 out lanes).
module tb_instbuf;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_squash;
  logic [3:0]   i_enq_vld;
  logic [127:0] i_enq_inst;
  logic [255:0] i_enq_pc;
  logic         o_can_enq;
  logic [3:0]   o_deq_vld;
  logic [127:0] o_deq_inst;
  logic [255:0] o_deq_pc;
  logic         i_deq_rdy;
  logic [4:0]   o_count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  instbuf dut (
    .clk        (clk),
    .rst        (rst),
    .i_squash   (i_squash),
    .i_enq_vld  (i_enq_vld),
    .i_enq_inst (i_enq_inst),
    .i_enq_pc   (i_enq_pc),
    .o_can_enq  (o_can_enq),
    .o_deq_vld  (o_deq_vld),
    .o_deq_inst (o_deq_inst),
    .o_deq_pc   (o_deq_pc),
    .i_deq_rdy  (i_deq_rdy),
    .o_count    (o_count)
  );

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic drive_enq(input logic [3:0] vld, input logic [63:0] pc0);
    i_enq_vld = vld;
    for (int k = 0; k < 4; k++) begin
      i_enq_pc[64*k +: 64]   = pc0 + 64'(4*k);
      i_enq_inst[32*k +: 32] = inst_of(pc0 + 64'(4*k));
    end
  endtask

  task automatic idle_inputs();
    i_squash  = 1'b0;
    i_deq_rdy = 1'b0;
    drive_enq(4'b0000, 64'h0);
  endtask

  // Advance one rising edge; sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    total++;
    if (o_count !== 5'd0) $display("FAIL reset_count: got %0d want 0", o_count);
    else passed++;
    total++;
    if (o_can_enq !== 1'b1) $display("FAIL reset_can_enq: got %b want 1", o_can_enq);
    else passed++;
    total++;
    if (o_deq_vld !== 4'b0000) $display("FAIL reset_vld: got %b want 0000", o_deq_vld);
    else passed++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_enq();
    drive_enq(4'b1111, 64'h1000);
    step();
    idle_inputs();
    #1;
    total++;
    if (o_count !== 5'd4) $display("FAIL basic_count: got %0d want 4", o_count);
    else passed++;
    total++;
    if (o_deq_vld !== 4'b1111) $display("FAIL basic_vld: got %b want 1111", o_deq_vld);
    else passed++;
    total++;
    if (o_deq_pc[63:0] !== 64'h1000)
      $display("FAIL basic_pc0: got %h want 1000", o_deq_pc[63:0]);
    else passed++;
    total++;
    if (o_deq_pc[255:192] !== 64'h100c)
      $display("FAIL basic_pc3: got %h want 100c", o_deq_pc[255:192]);
    else passed++;
    total++;
    if (o_deq_inst[63:32] !== 32'hC0DE1004)
      $display("FAIL basic_inst1: got %h want c0de1004", o_deq_inst[63:32]);
    else passed++;
  endtask

  // Continues from count 4 with head PC 0x1000.
  task automatic test_fill();
    for (int i = 1; i < 4; i++) begin
      drive_enq(4'b1111, 64'h1000 + 64'(16*i));
      step();
    end
    idle_inputs();
    #1;
    total++;
    if (o_count !== 5'd16) $display("FAIL full_count: got %0d want 16", o_count);
    else passed++;
    total++;
    if (o_can_enq !== 1'b0) $display("FAIL full_can_enq: got %b want 0", o_can_enq);
    else passed++;
    drive_enq(4'b1111, 64'h9000);
    step();
    idle_inputs();
    #1;
    total++;
    if (o_count !== 5'd16) $display("FAIL drop_count: got %0d want 16", o_count);
    else passed++;
    total++;
    if (o_deq_pc[63:0] !== 64'h1000)
      $display("FAIL drop_head_pc: got %h want 1000", o_deq_pc[63:0]);
    else passed++;
    i_squash = 1'b1;
    step();
    idle_inputs();
  endtask

  task automatic test_deq_enq();
    drive_enq(4'b0011, 64'h2000);
    step();
    i_deq_rdy = 1'b1;
    drive_enq(4'b0011, 64'h3000);
    #1;
    total++;
    if (o_deq_vld !== 4'b0011) $display("FAIL de_vld: got %b want 0011", o_deq_vld);
    else passed++;
    total++;
    if (o_deq_pc[127:64] !== 64'h2004)
      $display("FAIL de_old_pc1: got %h want 2004", o_deq_pc[127:64]);
    else passed++;
    step();
    idle_inputs();
    #1;
    total++;
    if (o_count !== 5'd2) $display("FAIL de_count: got %0d want 2", o_count);
    else passed++;
    total++;
    if (o_deq_pc[63:0] !== 64'h3000)
      $display("FAIL de_head_pc: got %h want 3000", o_deq_pc[63:0]);
    else passed++;
    i_deq_rdy = 1'b1;
    step();
    idle_inputs();
    #1;
    total++;
    if (o_count !== 5'd0) $display("FAIL de_drain: got %0d want 0", o_count);
    else passed++;
  endtask

  // Pointers sit at 4; 44 entries stream through, crossing slot 15->0 twice.
  task automatic test_wrap();
    logic [63:0] want;
    drive_enq(4'b1111, 64'h4000);
    step();
    for (int i = 0; i < 10; i++) begin
      drive_enq(4'b1111, 64'h4000 + 64'(16*(i+1)));
      i_deq_rdy = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
        want = 64'h4000 + 64'(16*i + 4*k);
        total++;
        if (o_deq_pc[64*k +: 64] !== want)
          $display("FAIL wrap_pc it%0d lane%0d: got %h want %h", i, k,
                   o_deq_pc[64*k +: 64], want);
        else passed++;
      end
      total++;
      if (o_count !== 5'd4) $display("FAIL wrap_count it%0d: got %0d want 4", i, o_count);
      else passed++;
      step();
    end
    idle_inputs();
    i_deq_rdy = 1'b1;
    step();
    idle_inputs();
    #1;
    total++;
    if (o_count !== 5'd0) $display("FAIL wrap_drain: got %0d want 0", o_count);
    else passed++;
  endtask

  task automatic test_squash();
    drive_enq(4'b1111, 64'h6000);
    step();
    drive_enq(4'b1111, 64'h6010);
    step();
    drive_enq(4'b0001, 64'h6020);
    step();
    idle_inputs();
    #1;
    total++;
    if (o_count !== 5'd9) $display("FAIL sq_pre_count: got %0d want 9", o_count);
    else passed++;
    i_squash  = 1'b1;
    i_deq_rdy = 1'b1;
    drive_enq(4'b1111, 64'h7000);
    #1;
    total++;
    if (o_deq_vld !== 4'b0000) $display("FAIL sq_vld_during: got %b want 0000", o_deq_vld);
    else passed++;
    step();
    idle_inputs();
    #1;
    total++;
    if (o_count !== 5'd0) $display("FAIL sq_count: got %0d want 0", o_count);
    else passed++;
    total++;
    if (o_deq_vld !== 4'b0000) $display("FAIL sq_vld_after: got %b want 0000", o_deq_vld);
    else passed++;
    total++;
    if (o_can_enq !== 1'b1) $display("FAIL sq_can_enq: got %b want 1", o_can_enq);
    else passed++;
  endtask

  task automatic test_partial();
    drive_enq(4'b1101, 64'h5000);
    step();
    idle_inputs();
    #1;
    total++;
    if (o_count !== 5'd1) $display("FAIL part_count: got %0d want 1", o_count);
    else passed++;
    total++;
    if (o_deq_vld !== 4'b0001) $display("FAIL part_vld: got %b want 0001", o_deq_vld);
    else passed++;
    total++;
    if (o_deq_pc[63:0] !== 64'h5000)
      $display("FAIL part_pc: got %h want 5000", o_deq_pc[63:0]);
    else passed++;
    i_deq_rdy = 1'b1;
    step();
    // Empty again: same pattern with the decoder ready.
    drive_enq(4'b1101, 64'h5100);
    i_deq_rdy = 1'b1;
    #1;
`ifdef INSTBUF_BYPASS_EN
    total++;
    if (o_deq_vld !== 4'b0001) $display("FAIL byp_vld: got %b want 0001", o_deq_vld);
    else passed++;
    total++;
    if (o_deq_pc[63:0] !== 64'h5100)
      $display("FAIL byp_pc: got %h want 5100", o_deq_pc[63:0]);
    else passed++;
    step();
    idle_inputs();
    #1;
    total++;
    if (o_count !== 5'd0) $display("FAIL byp_count: got %0d want 0", o_count);
    else passed++;
`else
    total++;
    if (o_deq_vld !== 4'b0000) $display("FAIL nobyp_vld: got %b want 0000", o_deq_vld);
    else passed++;
    step();
    idle_inputs();
    #1;
    total++;
    if (o_count !== 5'd1) $display("FAIL nobyp_count: got %0d want 1", o_count);
    else passed++;
    total++;
    if (o_deq_pc[63:0] !== 64'h5100)
      $display("FAIL nobyp_pc: got %h want 5100", o_deq_pc[63:0]);
    else passed++;
`endif
  endtask

  // Asynchronous reset with entries held, checked before any clock edge.
  task automatic test_reset_mid();
    drive_enq(4'b0111, 64'h8000);
    step();
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (o_count !== 5'd0) $display("FAIL amid_count: got %0d want 0", o_count);
    else passed++;
    total++;
    if (o_deq_vld !== 4'b0000) $display("FAIL amid_vld: got %b want 0000", o_deq_vld);
    else passed++;
    total++;
    if (o_can_enq !== 1'b1) $display("FAIL amid_can_enq: got %b want 1", o_can_enq);
    else passed++;
    step();
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_basic_enq();
    test_fill();
    test_deq_enq();
    test_wrap();
    test_squash();
    test_partial();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
